// File: rtl/piccolo_pkg.sv
// Piccolo cipher primitives shared by the iterative core: S-box, F function,
// round permutation, round constants and the key-size dependent round count.
package piccolo_pkg;

    localparam int unsigned WordBits = 16;
    // Blocks and keys are MSB-first: word 0 occupies the top 16 bits.
    localparam int unsigned Word0Msb = 63;
    localparam int unsigned Word1Msb = 47;
    localparam int unsigned Word2Msb = 31;
    localparam int unsigned Word3Msb = 15;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Round count for a key size; 0 flags an unsupported size.
    function automatic int unsigned nr_of(input int unsigned key_bits);
        return (key_bits == 80) ? 25 : (key_bits == 128) ? 31 : 0;
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] s;
        s = '0;
        case (x)
            4'h0: s = 4'he;
            4'h1: s = 4'h4;
            4'h2: s = 4'hb;
            4'h3: s = 4'h2;
            4'h4: s = 4'h3;
            4'h5: s = 4'h8;
            4'h6: s = 4'h0;
            4'h7: s = 4'h9;
            4'h8: s = 4'h1;
            4'h9: s = 4'ha;
            4'ha: s = 4'h7;
            4'hb: s = 4'hf;
            4'hc: s = 4'h6;
            4'hd: s = 4'hc;
            4'he: s = 4'h5;
            4'hf: s = 4'hd;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [15:0] sbox_layer(input logic [15:0] x);
        return {sbox(x[15:12]), sbox(x[11:8]), sbox(x[7:4]), sbox(x[3:0])};
    endfunction

    // GF(2^4) with x^4 + x + 1: reduction of the carried-out x^4 term is 4'h3.
    function automatic logic [3:0] gf_mul2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf_mul3(input logic [3:0] x);
        return gf_mul2(x) ^ x;
    endfunction

    // Matrix rows: (2 3 1 1) (1 2 3 1) (1 1 2 3) (3 1 1 2).
    function automatic logic [15:0] mix_column(input logic [15:0] x);
        logic [3:0] a, b, c, d;
        {a, b, c, d} = x;
        return {gf_mul2(a) ^ gf_mul3(b) ^ c ^ d,
                a ^ gf_mul2(b) ^ gf_mul3(c) ^ d,
                a ^ b ^ gf_mul2(c) ^ gf_mul3(d),
                gf_mul3(a) ^ b ^ c ^ gf_mul2(d)};
    endfunction

    function automatic logic [15:0] f_func(input logic [15:0] x);
        return sbox_layer(mix_column(sbox_layer(x)));
    endfunction

    // Byte map (x0..x7) -> (x2,x7,x4,x1,x6,x3,x0,x5), x0 = top byte.
    function automatic logic [63:0] rp(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    function automatic logic [31:0] con80(input logic [4:0] r);
        logic [4:0] c;
        c = r + 5'd1;
        return {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ 32'h0f1e_2d3c;
    endfunction

    function automatic logic [31:0] con128(input logic [4:0] r);
        logic [4:0] c;
        c = r + 5'd1;
        return {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ 32'h6547_a98b;
    endfunction

    // One step of the 128-bit key word permutation: new[a] = old[perm(a)].
    function automatic logic [2:0] perm128(input logic [2:0] a);
        logic [2:0] p;
        p = '0;
        case (a)
            3'd0: p = 3'd2;
            3'd1: p = 3'd1;
            3'd2: p = 3'd6;
            3'd3: p = 3'd7;
            3'd4: p = 3'd0;
            3'd5: p = 3'd3;
            3'd6: p = 3'd4;
            3'd7: p = 3'd5;
            default: p = '0;
        endcase
        return p;
    endfunction

    // Original key word feeding rk[j]: the schedule permutes the key every
    // time (j+2) reaches a multiple of 8, so compose that many permutations.
    function automatic logic [2:0] key_idx128(input logic [5:0] j);
        logic [5:0] t;
        logic [2:0] a;
        t = j + 6'd2;
        a = t[2:0];
        for (int n = 0; n < 7; n++) begin
            if (n < int'(t[5:3])) a = perm128(a);
        end
        return a;
    endfunction

endpackage

// File: rtl/piccolo_round.sv
// One combinational Piccolo round; can be bypassed so the unrolled chain can
// overshoot the round count.
module piccolo_round
    import piccolo_pkg::*;
(
    input  logic [63:0] state_i,
    input  logic [15:0] rk0_i,
    input  logic [15:0] rk1_i,
    input  logic        last_round_i,
    input  logic        bypass_i,
    output logic [63:0] state_o
);

    logic [15:0] w0, w1, w2, w3;
    logic [63:0] mixed;

    assign w0 = state_i[Word0Msb -: WordBits];
    assign w1 = state_i[Word1Msb -: WordBits];
    assign w2 = state_i[Word2Msb -: WordBits];
    assign w3 = state_i[Word3Msb -: WordBits];

    assign mixed   = {w0, w1 ^ f_func(w0) ^ rk0_i, w2, w3 ^ f_func(w2) ^ rk1_i};
    // The final round skips the permutation.
    assign state_o = bypass_i ? state_i : (last_round_i ? mixed : rp(mixed));

endmodule

// File: rtl/piccolo_core_param.sv
// Iterative Piccolo-80/128 encryption core, UNROLL rounds per clock, with
// valid/ready on both sides and a runtime-loaded key.
module piccolo_core_param
    import piccolo_pkg::*;
#(
    parameter int unsigned KEY_BITS = 80,
    parameter int unsigned UNROLL   = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [63:0]         plaintext_i,
    input  logic [KEY_BITS-1:0] key_in_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [63:0]         ciphertext_o,
    output logic                busy_o
);

    localparam int unsigned NR = nr_of(KEY_BITS);
    localparam int unsigned NK = KEY_BITS / 16;

    if (NR == 0 || UNROLL < 1 || UNROLL > 4) begin : g_bad_cfg
        $error("piccolo_core_param: KEY_BITS must be 80/128 and UNROLL 1..4");
    end

    state_e              st_q, st_d;
    logic [4:0]          rnd_q, rnd_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [63:0]         blk_q, blk_d;
    logic [63:0]         ct_q, ct_d;

    logic [15:0] kq [NK];
    logic [15:0] wk0_in, wk1_in, wk2, wk3;
    logic [63:0] chain [UNROLL+1];
    logic        last_step;

    for (genvar i = 0; i < NK; i++) begin : g_kw
        assign kq[i] = key_q[KEY_BITS-1-16*i -: 16];
    end

    // Input whitening uses the key being accepted, not the stale register.
    assign wk0_in = {key_in_i[KEY_BITS-1 -: 8], key_in_i[KEY_BITS-25 -: 8]};
    assign wk1_in = {key_in_i[KEY_BITS-17 -: 8], key_in_i[KEY_BITS-9 -: 8]};

    if (KEY_BITS == 80) begin : g_wk80
        assign wk2 = {kq[4][15:8], kq[3][7:0]};
        assign wk3 = {kq[3][15:8], kq[4][7:0]};
    end else begin : g_wk128
        assign wk2 = {kq[4][15:8], kq[7][7:0]};
        assign wk3 = {kq[7][15:8], kq[4][7:0]};
    end

    assign chain[0] = blk_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [5:0]  r;
        logic [15:0] rk0, rk1;
        logic        last_round, bypass;

        assign r          = {1'b0, rnd_q} + 6'(u);
        assign last_round = (r == 6'(NR - 1));
        assign bypass     = (r >= 6'(NR));

        if (KEY_BITS == 80) begin : g_k80
            logic [31:0] con;
            logic [15:0] base0, base1;
            assign con = con80(r[4:0]);
            // Subkey pair cycles with period 5: (k2,k3) (k0,k1) (k2,k3) (k4,k4) (k0,k1).
            always_comb begin
                base0 = kq[2];
                base1 = kq[3];
                case (r % 6'd5)
                    6'd1, 6'd4: begin
                        base0 = kq[0];
                        base1 = kq[1];
                    end
                    6'd3: begin
                        base0 = kq[4];
                        base1 = kq[4];
                    end
                    default: ;
                endcase
            end
            assign rk0 = base0 ^ con[31:16];
            assign rk1 = base1 ^ con[15:0];
        end else begin : g_k128
            logic [31:0] con;
            logic [2:0]  idx0, idx1;
            assign con  = con128(r[4:0]);
            assign idx0 = key_idx128({r[4:0], 1'b0});
            assign idx1 = key_idx128({r[4:0], 1'b1});
            assign rk0  = kq[idx0] ^ con[31:16];
            assign rk1  = kq[idx1] ^ con[15:0];
        end

        piccolo_round u_round (
            .state_i     (chain[u]),
            .rk0_i       (rk0),
            .rk1_i       (rk1),
            .last_round_i(last_round),
            .bypass_i    (bypass),
            .state_o     (chain[u+1])
        );
    end

    assign last_step = (({1'b0, rnd_q} + 6'(UNROLL)) >= 6'(NR));

    // Next-state: accept and whiten in IDLE, iterate in RUN, hold in DONE.
    always_comb begin
        st_d  = st_q;
        rnd_d = rnd_q;
        key_d = key_q;
        blk_d = blk_q;
        ct_d  = ct_q;
        unique case (st_q)
            StIdle: begin
                if (in_valid_i) begin
                    key_d = key_in_i;
                    blk_d = {plaintext_i[63:48] ^ wk0_in, plaintext_i[47:32],
                             plaintext_i[31:16] ^ wk1_in, plaintext_i[15:0]};
                    rnd_d = '0;
                    st_d  = StRun;
                end
            end
            StRun: begin
                blk_d = chain[UNROLL];
                if (last_step) begin
                    ct_d  = {chain[UNROLL][63:48] ^ wk2, chain[UNROLL][47:32],
                             chain[UNROLL][31:16] ^ wk3, chain[UNROLL][15:0]};
                    rnd_d = '0;
                    st_d  = StDone;
                end else begin
                    rnd_d = rnd_q + 5'(UNROLL);
                end
            end
            StDone: begin
                if (out_ready_i) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q  <= StIdle;
            rnd_q <= '0;
            key_q <= '0;
            blk_q <= '0;
            ct_q  <= '0;
        end else begin
            st_q  <= st_d;
            rnd_q <= rnd_d;
            key_q <= key_d;
            blk_q <= blk_d;
            ct_q  <= ct_d;
        end
    end

    assign in_ready_o   = (st_q == StIdle);
    assign busy_o       = (st_q == StRun);
    assign out_valid_o  = (st_q == StDone);
    assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_piccolo_core_param.sv
// Bench for piccolo_core_param: six instances (80-bit UNROLL 1..4, 128-bit
// UNROLL 1 and 4) against directed vectors and an independent cipher model.
module tb_piccolo_core_param;

    localparam logic [63:0] SBOX_T = 64'he4b2_3809_1a7f_6c5d;
    localparam logic [63:0] MIX_T  = 64'h2311_1231_1123_3112;
    localparam logic [31:0] RP_T   = 32'h2741_6305;
    localparam logic [79:0] KEY80  = 80'h0011_2233_4455_6677_8899;
    localparam logic [127:0] KEY128 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    localparam logic [63:0] PT_V   = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] CT80_V = 64'h8d2b_ff99_35f8_4056;

    logic         clk, rst, out_ready;
    logic [5:0]   iv, ir, ov, bz;
    logic [63:0]  pt;
    logic [79:0]  k80;
    logic [127:0] k128;
    logic [63:0]  ct [6];

    int           checks, failures;
    int           lat_r [6];
    logic [63:0]  ct_r [6];
    logic [5:0]   bz_first, ir_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar d = 0; d < 6; d++) begin : g_dut
        if (d < 4) begin : g_k80
            piccolo_core_param #(.KEY_BITS(80), .UNROLL(d + 1)) u_dut (
                .clk_i(clk), .reset_i(rst), .in_valid_i(iv[d]), .in_ready_o(ir[d]),
                .plaintext_i(pt), .key_in_i(k80), .out_valid_o(ov[d]),
                .out_ready_i(out_ready), .ciphertext_o(ct[d]), .busy_o(bz[d]));
        end else begin : g_k128
            piccolo_core_param #(.KEY_BITS(128), .UNROLL(d == 4 ? 1 : 4)) u_dut (
                .clk_i(clk), .reset_i(rst), .in_valid_i(iv[d]), .in_ready_o(ir[d]),
                .plaintext_i(pt), .key_in_i(k128), .out_valid_o(ov[d]),
                .out_ready_i(out_ready), .ciphertext_o(ct[d]), .busy_o(bz[d]));
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        logic [63:0] t;
        t = SBOX_T;
        return t[63-4*x -: 4];
    endfunction

    function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, aa, bb;
        logic       carry;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 4; i++) begin
            if (bb[0]) p = p ^ aa;
            bb    = bb >> 1;
            carry = aa[3];
            aa    = {aa[2:0], 1'b0};
            if (carry) aa = aa ^ 4'h3;
        end
        return p;
    endfunction

    function automatic logic [15:0] m_f(input logic [15:0] x);
        logic [3:0]  n [4];
        logic [3:0]  y;
        logic [15:0] o;
        logic [63:0] m;
        m = MIX_T;
        o = '0;
        for (int i = 0; i < 4; i++) n[i] = m_sbox(x[15-4*i -: 4]);
        for (int r = 0; r < 4; r++) begin
            y = '0;
            for (int c = 0; c < 4; c++) y = y ^ m_gmul(m[63-4*(4*r+c) -: 4], n[c]);
            o[15-4*r -: 4] = m_sbox(y);
        end
        return o;
    endfunction

    function automatic logic [63:0] m_rp(input logic [63:0] x);
        logic [31:0] p;
        logic [63:0] o;
        int          idx;
        p = RP_T;
        o = '0;
        for (int j = 0; j < 8; j++) begin
            idx = int'(p[31-4*j -: 4]);
            o[63-8*j -: 8] = x[63-8*idx -: 8];
        end
        return o;
    endfunction

    // Key is right-aligned in 'key'; kb selects 80 or 128.
    function automatic logic [63:0] m_encrypt(input int kb, input logic [127:0] key,
                                              input logic [63:0] p);
        logic [15:0] k [8];
        logic [15:0] t [8];
        logic [15:0] rk [62];
        logic [15:0] cn [62];
        logic [15:0] x [4];
        logic [15:0] wk [4];
        logic [4:0]  c;
        logic [31:0] cv;
        logic [63:0] o;
        int          nr;
        nr = (kb == 80) ? 25 : 31;
        for (int i = 0; i < 8; i++) k[i] = '0;
        for (int i = 0; i < 62; i++) begin rk[i] = '0; cn[i] = '0; end
        for (int i = 0; i < kb / 16; i++) k[i] = key[kb-1-16*i -: 16];
        wk[0] = {k[0][15:8], k[1][7:0]};
        wk[1] = {k[1][15:8], k[0][7:0]};
        if (kb == 80) begin
            wk[2] = {k[4][15:8], k[3][7:0]};
            wk[3] = {k[3][15:8], k[4][7:0]};
            for (int i = 0; i < 25; i++) begin
                c  = 5'(i + 1);
                cv = {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ 32'h0f1e2d3c;
                case (i % 5)
                    0, 2: begin rk[2*i] = k[2] ^ cv[31:16]; rk[2*i+1] = k[3] ^ cv[15:0]; end
                    1, 4: begin rk[2*i] = k[0] ^ cv[31:16]; rk[2*i+1] = k[1] ^ cv[15:0]; end
                    default: begin rk[2*i] = k[4] ^ cv[31:16]; rk[2*i+1] = k[4] ^ cv[15:0]; end
                endcase
            end
        end else begin
            wk[2] = {k[4][15:8], k[7][7:0]};
            wk[3] = {k[7][15:8], k[4][7:0]};
            for (int i = 0; i < 31; i++) begin
                c  = 5'(i + 1);
                cv = {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ 32'h6547a98b;
                cn[2*i]   = cv[31:16];
                cn[2*i+1] = cv[15:0];
            end
            for (int i = 0; i < 62; i++) begin
                if ((i + 2) % 8 == 0) begin
                    t = k;
                    k = '{t[2], t[1], t[6], t[7], t[0], t[3], t[4], t[5]};
                end
                rk[i] = k[(i + 2) % 8] ^ cn[i];
            end
        end
        x[0] = p[63:48] ^ wk[0];
        x[1] = p[47:32];
        x[2] = p[31:16] ^ wk[1];
        x[3] = p[15:0];
        for (int r = 0; r < nr; r++) begin
            x[1] = x[1] ^ m_f(x[0]) ^ rk[2*r];
            x[3] = x[3] ^ m_f(x[2]) ^ rk[2*r+1];
            if (r != nr - 1) begin
                o = m_rp({x[0], x[1], x[2], x[3]});
                x[0] = o[63:48]; x[1] = o[47:32]; x[2] = o[31:16]; x[3] = o[15:0];
            end
        end
        return {x[0] ^ wk[2], x[1], x[2] ^ wk[3], x[3]};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Offer one block to all six instances; record first out_valid cycle and value.
    task automatic run_all(input logic [79:0] k8, input logic [127:0] k12, input logic [63:0] p);
        bit all_seen;
        k80 = k8; k128 = k12; pt = p; iv = '1;
        @(posedge clk); #1;
        iv = '0;
        bz_first = bz;
        ir_first = ir;
        for (int d = 0; d < 6; d++) lat_r[d] = 0;
        for (int n = 1; n <= 50; n++) begin
            for (int d = 0; d < 6; d++) begin
                if (lat_r[d] == 0 && ov[d]) begin lat_r[d] = n; ct_r[d] = ct[d]; end
            end
            all_seen = 1'b1;
            for (int d = 0; d < 6; d++) if (lat_r[d] == 0) all_seen = 1'b0;
            if (all_seen) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Called #1 after the accept edge; returns latency in cycles (bounded).
    task automatic wait_ov1(output int n);
        n = 1;
        while (!ov[1] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (ir !== 6'h3f || ov !== 6'h00 || bz !== 6'h00) begin
            failures++;
            $display("FAIL reset_flags got ir=%h ov=%h bz=%h exp ir=3f ov=00 bz=00", ir, ov, bz);
        end
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (ct[d] !== 64'h0) begin
                failures++;
                $display("FAIL reset_ct d=%0d got=%h exp=0", d, ct[d]);
            end
        end
    endtask

    task automatic test_vectors();
        int          exp_lat [6];
        logic [63:0] exp_ct [6];
        exp_lat = '{26, 14, 10, 8, 32, 9};
        for (int d = 0; d < 4; d++) exp_ct[d] = CT80_V;
        exp_ct[4] = m_encrypt(128, KEY128, PT_V);
        exp_ct[5] = exp_ct[4];
        run_all(KEY80, KEY128, PT_V);
        checks++;
        if (bz_first !== 6'h3f || ir_first !== 6'h00) begin
            failures++;
            $display("FAIL vec_run_flags got bz=%h ir=%h exp bz=3f ir=00", bz_first, ir_first);
        end
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (lat_r[d] !== exp_lat[d]) begin
                failures++;
                $display("FAIL vec_latency d=%0d got=%0d exp=%0d", d, lat_r[d], exp_lat[d]);
            end
            checks++;
            if (ct_r[d] !== exp_ct[d]) begin
                failures++;
                $display("FAIL vec_ct d=%0d got=%h exp=%h", d, ct_r[d], exp_ct[d]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] rk;
        logic [63:0]  rp, e80, e128;
        int           exp_lat [6];
        exp_lat = '{26, 14, 10, 8, 32, 9};
        for (int it = 0; it < 1000; it++) begin
            rk   = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp   = {$urandom(), $urandom()};
            e80  = m_encrypt(80, {48'h0, rk[79:0]}, rp);
            e128 = m_encrypt(128, rk, rp);
            run_all(rk[79:0], rk, rp);
            for (int d = 0; d < 6; d++) begin
                checks++;
                if (ct_r[d] !== ((d < 4) ? e80 : e128) || lat_r[d] !== exp_lat[d]) begin
                    failures++;
                    $display("FAIL rand it=%0d d=%0d got=%h/%0d exp=%h/%0d", it, d, ct_r[d],
                             lat_r[d], (d < 4) ? e80 : e128, exp_lat[d]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          n;
        bit          held;
        logic [79:0] k2;
        logic [63:0] p2, e2;
        k2 = 80'hfedc_ba98_7654_3210_1357;
        p2 = 64'hdead_beef_0bad_f00d;
        e2 = m_encrypt(80, {48'h0, k2}, p2);
        out_ready = 1'b0;
        k80 = KEY80; pt = PT_V; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        wait_ov1(n);
        checks++;
        if (ov[1] !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_valid got=%b exp=1 after %0d cycles", ov[1], n);
        end
        // Offer the next block while stalled; it must be ignored until handshake.
        k80 = k2; pt = p2; iv[1] = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ct[1] !== CT80_V || ir[1] !== 1'b0 || ov[1] !== 1'b1) held = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (held !== 1'b1 || ct[1] !== CT80_V) begin
            failures++;
            $display("FAIL bp_hold got ct=%h ir=%b ov=%b exp ct=%h ir=0 ov=1", ct[1], ir[1],
                     ov[1], CT80_V);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || bz[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ov=%b ir=%b bz=%b exp ov=0 ir=1 bz=0", ov[1], ir[1],
                     bz[1]);
        end
        @(posedge clk); #1;
        iv[1] = 1'b0;
        checks++;
        if (bz[1] !== 1'b1 || ir[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept got bz=%b ir=%b exp bz=1 ir=0", bz[1], ir[1]);
        end
        wait_ov1(n);
        checks++;
        if (ct[1] !== e2 || n !== 14) begin
            failures++;
            $display("FAIL bp_second got=%h/%0d exp=%h/14", ct[1], n, e2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [79:0] ka, kb;
        logic [63:0] pa, pb, ea, eb;
        ka = 80'h1111_2222_3333_4444_5555;
        kb = 80'h9abc_def0_1234_5678_0f0f;
        pa = 64'h0000_0000_0000_0000;
        pb = 64'hffff_0000_ffff_0000;
        ea = m_encrypt(80, {48'h0, ka}, pa);
        eb = m_encrypt(80, {48'h0, kb}, pb);
        k80 = ka; pt = pa; iv[1] = 1'b1;
        @(posedge clk); #1;
        // Change key and plaintext mid-RUN and keep offering block B.
        k80 = kb; pt = pb;
        wait_ov1(n);
        checks++;
        if (ct[1] !== ea || ov[1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got=%h ov=%b exp=%h ov=1", ct[1], ov[1], ea);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        checks++;
        if (bz[1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_accept got bz=%b exp=1", bz[1]);
        end
        wait_ov1(n);
        checks++;
        if (ct[1] !== eb || ov[1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second got=%h ov=%b exp=%h ov=1", ct[1], ov[1], eb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int          n;
        bit          seen;
        logic [63:0] p2, e2;
        p2 = 64'h0f0f_1e1e_2d2d_3c3c;
        e2 = m_encrypt(80, {48'h0, KEY80}, p2);
        k80 = KEY80; pt = PT_V; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || bz[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got ov=%b ir=%b bz=%b exp ov=0 ir=1 bz=0", ov[1], ir[1], bz[1]);
        end
        seen = 1'b0;
        repeat (20) begin
            if (ov[1]) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_output got valid=%b exp=0", seen);
        end
        pt = p2; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        wait_ov1(n);
        checks++;
        if (ct[1] !== e2 || n !== 14) begin
            failures++;
            $display("FAIL rst_fresh got=%h/%0d exp=%h/14", ct[1], n, e2);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        iv = '0;
        out_ready = 1'b1;
        pt = '0;
        k80 = '0;
        k128 = '0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
